// File: rtl/md_defs_pkg.sv
// Shared multiply/divide definitions: MDOp encodings, default latencies and FSM states.
// Imported by md_unit and by the decoder and hazard unit that issue MD operations.
package md_defs;

    localparam int unsigned DATA_W           = 32;
    localparam int unsigned MD_OP_W          = 3;
    localparam int unsigned MULT_CYCLES_DEF  = 5;
    localparam int unsigned DIV_CYCLES_DEF   = 10;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_e;

    // True for the opcodes that start a multi-cycle operation.
    function automatic logic is_md_start(input logic [MD_OP_W-1:0] op);
        return (op >= 3'(MD_MULT)) && (op <= 3'(MD_DIVU));
    endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed combinationally from latched operands and committed when the counter expires.
module md_unit
    import md_defs::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [MD_OP_W-1:0]  MDOpE,
    input  logic                startE,
    input  logic [DATA_W-1:0]   SrcAE,
    input  logic [DATA_W-1:0]   SrcBE,
    output logic                busy,
    output logic [DATA_W-1:0]   HI,
    output logic [DATA_W-1:0]   LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);
    localparam int unsigned PROD_W     = 2 * DATA_W;

    md_state_e           state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    md_op_e              op_q, op_n;
    logic [DATA_W-1:0]   a_q, a_n, b_q, b_n;
    logic [DATA_W-1:0]   hi_n, lo_n;

    logic [DATA_W-1:0]   res_hi, res_lo;
    logic                res_valid;

    // Result datapath, driven only by the latched operands.
    logic [PROD_W-1:0]        prod_s, prod_u;
    logic signed [DATA_W-1:0] dvd_s, dvs_s, quo_s, rem_s;
    logic [DATA_W-1:0]        dvs_u, quo_u, rem_u;
    logic                     div_zero, div_ovf;

    always_comb begin
        prod_s   = {{DATA_W{a_q[DATA_W-1]}}, a_q} * {{DATA_W{b_q[DATA_W-1]}}, b_q};
        prod_u   = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
        div_zero = (b_q == '0);
        // Most-negative / -1 overflows a 32-bit quotient; pin it to the wrapped result.
        div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
        dvs_u    = div_zero ? 32'd1 : b_q;
        dvd_s    = div_ovf ? 32'sd0 : $signed(a_q);
        dvs_s    = $signed(dvs_u);
        quo_s    = dvd_s / dvs_s;
        rem_s    = dvd_s % dvs_s;
        quo_u    = a_q / dvs_u;
        rem_u    = a_q % dvs_u;

        res_valid = 1'b1;
        res_hi    = '0;
        res_lo    = '0;
        unique case (op_q)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                res_valid = !div_zero;
                res_lo    = div_ovf ? 32'h8000_0000 : $unsigned(quo_s);
                res_hi    = div_ovf ? 32'h0000_0000 : $unsigned(rem_s);
            end
            MD_DIVU: begin
                res_valid = !div_zero;
                res_lo    = quo_u;
                res_hi    = rem_u;
            end
            default: res_valid = 1'b0;
        endcase
    end

    // Next-state and register-update logic.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_n    = op_q;
        a_n     = a_q;
        b_n     = b_q;
        hi_n    = HI;
        lo_n    = LO;

        unique case (state)
            S_IDLE: begin
                if (startE && is_md_start(MDOpE)) begin
                    op_n    = md_op_e'(MDOpE);
                    a_n     = SrcAE;
                    b_n     = SrcBE;
                    cnt_n   = (MDOpE <= 3'(MD_MULTU)) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    state_n = S_BUSY;
                end else if (MDOpE == 3'(MD_MTHI)) begin
                    hi_n = SrcAE;
                end else if (MDOpE == 3'(MD_MTLO)) begin
                    lo_n = SrcAE;
                end
            end
            S_BUSY: begin
                if (cnt <= CNT_W'(1)) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    if (res_valid) begin
                        hi_n = res_hi;
                        lo_n = res_lo;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= MD_NONE;
            a_q   <= '0;
            b_q   <= '0;
            busy  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            op_q  <= op_n;
            a_q   <= a_n;
            b_q   <= b_n;
            busy  <= (state_n == S_BUSY);
            HI    <= hi_n;
            LO    <= lo_n;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: table of mult/div vectors through a scoreboard queue,
// plus hand sequences for mthi/mtlo, divide by zero, busy-time injection and reset abort.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  MDOpE;
    logic        startE;
    logic [31:0] SrcAE, SrcBE;
    logic        busy;
    logic [31:0] HI, LO;

    md_unit dut (
        .clk    (clk),
        .reset  (reset),
        .MDOpE  (MDOpE),
        .startE (startE),
        .SrcAE  (SrcAE),
        .SrcBE  (SrcBE),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[10];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_hi, m_lo;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic write_mt(input logic [2:0] op, input logic [31:0] val);
        @(negedge clk);
        MDOpE = op;
        SrcAE = val;
        @(negedge clk);
        MDOpE = 3'd0;
        SrcAE = $urandom;
        if (op == 3'd5) m_hi = val;
        else            m_lo = val;
    endtask

    // Issue one mult/div op, track the busy window, and compare against the scoreboard entry.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input bit keep, input bit inject);
        exp_t e;
        int   cyc;
        e.hi  = keep ? m_hi : ehi;
        e.lo  = keep ? m_lo : elo;
        e.cyc = (op <= 3'd2) ? 5 : 10;
        sb.push_back(e);

        @(negedge clk);
        MDOpE  = op;
        startE = 1'b1;
        SrcAE  = a;
        SrcBE  = b;
        @(negedge clk);
        startE = 1'b0;
        MDOpE  = 3'd0;
        SrcAE  = $urandom;
        SrcBE  = $urandom;

        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            check32({name, "_hold_hi"}, HI, m_hi);
            check32({name, "_hold_lo"}, LO, m_lo);
            if (inject && cyc == 2) begin
                MDOpE = 3'd5;
                SrcAE = 32'hCAFE_F00D;
            end else if (inject && cyc == 3) begin
                MDOpE  = 3'd1;
                startE = 1'b1;
                SrcAE  = 32'h0000_0007;
                SrcBE  = 32'h0000_0009;
            end else if (inject && cyc == 4) begin
                MDOpE  = 3'd0;
                startE = 1'b0;
            end
            @(negedge clk);
        end

        e = sb.pop_front();
        check_int({name, "_busy_cycles"}, cyc, e.cyc);
        check32({name, "_hi"}, HI, e.hi);
        check32({name, "_lo"}, LO, e.lo);
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    initial begin
        vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1] = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{3'd4, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
        vecs[4] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[6] = '{3'd1, 32'hFFFF_FFFD, 32'h0000_0004, 32'hFFFF_FFFF, 32'hFFFF_FFF4};
        vecs[7] = '{3'd2, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[8] = '{3'd4, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999};
        vecs[9] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

        reset  = 1'b1;
        MDOpE  = 3'd0;
        startE = 1'b0;
        SrcAE  = '0;
        SrcBE  = '0;
        m_hi   = '0;
        m_lo   = '0;
        repeat (3) @(negedge clk);
        check32("reset_busy", {31'd0, busy}, 32'd0);
        check32("reset_hi", HI, 32'd0);
        check32("reset_lo", LO, 32'd0);
        reset = 1'b0;

        write_mt(3'd5, 32'hDEAD_BEEF);
        check32("mthi_hi", HI, 32'hDEAD_BEEF);
        check32("mthi_busy", {31'd0, busy}, 32'd0);
        write_mt(3'd6, 32'h1234_5678);
        check32("mtlo_lo", LO, 32'h1234_5678);
        check32("mtlo_hi_kept", HI, 32'hDEAD_BEEF);

        // Illegal start opcode and a bare start with op 0 must change nothing.
        @(negedge clk);
        startE = 1'b1;
        MDOpE  = 3'd7;
        SrcAE  = 32'h5555_5555;
        @(negedge clk);
        MDOpE  = 3'd0;
        @(negedge clk);
        startE = 1'b0;
        check32("illegal_busy", {31'd0, busy}, 32'd0);
        check32("illegal_hi", HI, m_hi);
        check32("illegal_lo", LO, m_lo);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, 1'b0, 1'b0);
        end

        write_mt(3'd5, 32'h0000_0011);
        write_mt(3'd6, 32'h0000_0022);
        run_op("divu_by_zero", 3'd4, 32'h0000_0007, 32'h0000_0000, 32'h0, 32'h0, 1'b1, 1'b0);
        run_op("div_by_zero", 3'd3, 32'hFFFF_FFF9, 32'h0000_0000, 32'h0, 32'h0, 1'b1, 1'b0);

        run_op("mult_inject", 3'd1, 32'h0000_0003, 32'h0000_0004, 32'h0, 32'h0000_000C, 1'b0, 1'b1);
        check32("inject_idle_busy", {31'd0, busy}, 32'd0);

        // Reset in busy cycle 3 aborts the op and clears HI/LO immediately.
        write_mt(3'd5, 32'h0000_00AA);
        @(negedge clk);
        MDOpE  = 3'd1;
        startE = 1'b1;
        SrcAE  = 32'd3;
        SrcBE  = 32'd4;
        @(negedge clk);
        MDOpE  = 3'd0;
        startE = 1'b0;
        repeat (2) @(negedge clk);
        check32("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check32("abort_busy", {31'd0, busy}, 32'd0);
        check32("abort_hi", HI, 32'd0);
        check32("abort_lo", LO, 32'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        run_op("mult_after_abort", 3'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0);

        // A start seen only while reset is high must not be accepted.
        @(negedge clk);
        reset  = 1'b1;
        MDOpE  = 3'd3;
        startE = 1'b1;
        SrcAE  = 32'd9;
        SrcBE  = 32'd2;
        @(negedge clk);
        reset  = 1'b0;
        MDOpE  = 3'd0;
        startE = 1'b0;
        @(negedge clk);
        check32("start_in_reset_busy", {31'd0, busy}, 32'd0);
        check32("start_in_reset_lo", LO, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
